mem_scan_display: RTL and testbench
===================================

Name: mem_scan_display

Overview:
- Read-side companion to the switch-driven register file.
- On a start pulse it walks every register address in turn and issues a read.
- It captures each returned byte and shows it as two hex digits on the time-multiplexed 2-digit seven-segment display.
- It sits between the register file's read port and the board's segment pins; start/step come from debounced buttons.

Parameters:
- ADDR_W, 3, register-file address width; scans 2**ADDR_W entries.
- RD_LAT, 1, cycles from rd_en to valid rd_data (1..3).
- DWELL_CYC, 50000000, cycles each value is held in auto mode (>=2).
- REFRESH_CYC, 100000, cycles per digit before seg_Tg_out toggles (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse (debounced); begins a scan
- step  in  1  single-cycle pulse (debounced); advances in manual mode
- auto_mode  in  1  1 = advance on dwell timeout, 0 = advance on step
- rd_en  out  1  read strobe to register file
- rd_addr  out  ADDR_W  read address
- rd_data  in  8  read data, valid RD_LAT cycles after rd_en
- busy  out  1  high from start acceptance until scan ends
- done  out  1  one-cycle pulse after the last entry's display period
- seg_Tg_out  out  1  digit select: 0 = low nibble, 1 = high nibble
- seg  out  7  {g,f,e,d,c,b,a}, active-low

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high.
- Reset values:
  - state IDLE; rd_en=0, rd_addr=0, busy=0, done=0.
  - display register cleared, blank flag set, so seg=7'b1111111 on both digits.
  - seg_Tg_out=0; dwell and refresh counters = 0.
- States: IDLE, REQ, WAIT, SHOW, DONE.
- IDLE:
  - start=1 -> REQ with rd_addr=0, busy=1.
  - step is ignored; display keeps its last value.
- REQ: rd_en=1 for exactly one cycle at the current rd_addr, then -> WAIT.
- WAIT:
  - Counts RD_LAT cycles after the rd_en cycle.
  - On the RD_LAT-th cycle, captures rd_data into the display register, clears blank, -> SHOW.
  - Net: a new value appears on seg RD_LAT+1 cycles after REQ is entered.
- SHOW, advance condition:
  - auto_mode=1: dwell counter reaches DWELL_CYC-1.
  - auto_mode=0: step=1.
  - step and dwell expiry in the same cycle cause a single advance.
  - auto_mode is sampled every cycle; switching it mid-SHOW resets the dwell counter.
- SHOW, on advance:
  - rd_addr != max: rd_addr+1 -> REQ.
  - rd_addr == max: -> DONE.
- DONE: done=1 for one cycle, busy=0, -> IDLE; rd_addr returns to 0 and the last value stays displayed.
- start while busy=1 is ignored.
- rst asserted in any state returns to the reset values on the next edge; any in-flight read data is discarded.
- Display mux:
  - Refresh counter is free-running, independent of state.
  - seg_Tg_out toggles when the counter reaches REFRESH_CYC-1.
  - seg is combinational from seg_Tg_out, the display register and the blank flag.
- Hex glyphs (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Optional Feature:
- Macro: MEM_SCAN_LOOP_EN.
- Defined:
  - At the last address the block wraps to address 0 -> REQ instead of DONE; busy stays 1 and done is never pulsed.
  - A start pulse while busy ends the scan at the next advance point (-> DONE -> IDLE).
- Undefined: single pass as described above; start while busy is ignored.

Decomposition:
- Shared package mem_scan_pkg holds:
  - state enum (IDLE, REQ, WAIT, SHOW, DONE);
  - SEG_BLANK constant;
  - 16-entry hex glyph constant table.
- One sub-module: hex_to_7seg, a 4-bit nibble plus blank input producing 7-bit active-low seg.
- Counters and the FSM stay in mem_scan_display.

Test Plan:
- Bench parameters: ADDR_W=3, RD_LAT=1, DWELL_CYC=4, REFRESH_CYC=2; memory model returns 8'h10+addr.
- Reset: rst high 3 cycles -> seg=7'b1111111, rd_en=0, busy=0, done=0, seg_Tg_out=0.
- Auto scan:
  - start pulse, auto_mode=1 -> rd_en pulses at addr 0..7, spaced 7 cycles apart.
  - After addr 5 is captured, seg shows 1111001 when seg_Tg_out=1 and 0010010 when seg_Tg_out=0.
  - done pulses once after the addr-7 display period; busy then 0.
- Manual mode: auto_mode=0, start -> stays on addr 0 (shows "10") indefinitely; 3 step pulses -> addr 3; step during REQ/WAIT is ignored.
- Collision: step coincident with dwell expiry in auto mode -> rd_addr increments by exactly 1.
- Disturbance:
  - start pulsed during SHOW of addr 2 -> no restart.
  - rst asserted during WAIT -> IDLE next edge, display blank, no capture.
- MEM_SCAN_LOOP_EN: after addr 7, next rd_en is at addr 0 and done stays 0; a start pulse -> done pulse at the next advance, then busy=0.

Source files
------------

// File: rtl/mem_scan_pkg.sv
// mem_scan_pkg
//   Shared definitions for the register-file scan/display block:
//   - state_t   : scan FSM states (IDLE, REQ, WAIT, SHOW, DONE)
//   - SEG_BLANK : active-low pattern with every segment off
//   - HEX_GLYPH : active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
package mem_scan_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      SHOW = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] HEX_GLYPH [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg
//   Purely combinational nibble-to-glyph decoder for an active-low
//   seven-segment digit.
//   Ports:
//     nibble  in  4  hex value to show
//     blank   in  1  1 = all segments off regardless of nibble
//     seg     out 7  {g,f,e,d,c,b,a}, active-low
module hex_to_7seg
   import mem_scan_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);

   assign seg = blank ? SEG_BLANK : HEX_GLYPH[nibble];

endmodule

// File: rtl/mem_scan_display.sv
// mem_scan_display
//   On a start pulse, walks every register-file address, reads each byte and
//   shows it as two hex digits on a time-multiplexed 2-digit seven-segment
//   display. Values advance on a dwell timeout (auto_mode=1) or on a step
//   pulse (auto_mode=0).
//
//   Optional build macro MEM_SCAN_LOOP_EN: the scan wraps from the last
//   address back to 0 instead of finishing, and a start pulse while busy
//   ends the scan at the next advance point.
//
//   Ports:
//     clk         in   1       system clock
//     rst         in   1       synchronous active-high reset
//     start       in   1       single-cycle pulse, begins a scan
//     step        in   1       single-cycle pulse, advances in manual mode
//     auto_mode   in   1       1 = dwell-timed advance, 0 = step advance
//     rd_en       out  1       read strobe to register file
//     rd_addr     out  ADDR_W  read address
//     rd_data     in   8       read data
//     busy        out  1       high while a scan is in progress
//     done        out  1       one-cycle pulse when the scan ends
//     seg_Tg_out  out  1       digit select: 0 = low nibble, 1 = high nibble
//     seg         out  7       {g,f,e,d,c,b,a}, active-low
//
//   Read handshake: rd_en is a single-cycle strobe with rd_addr stable in
//   that cycle; the register file has no ready/stall, and rd_data is taken
//   as valid exactly RD_LAT cycles after the rd_en cycle, with no
//   acknowledge back.
module mem_scan_display
   import mem_scan_pkg::*;
#(
   parameter int ADDR_W      = 3,
   parameter int RD_LAT      = 1,
   parameter int DWELL_CYC   = 50000000,
   parameter int REFRESH_CYC = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              step,
   input  logic              auto_mode,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              busy,
   output logic              done,
   output logic              seg_Tg_out,
   output logic [6:0]        seg
);

   localparam int WAIT_W  = 2;
   localparam int DWELL_W = $clog2(DWELL_CYC);
   localparam int REF_W   = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  rd_addr_q;
   logic [WAIT_W-1:0]  wait_cnt_q;
   logic [DWELL_W-1:0] dwell_cnt_q;
   logic               dwell_hit_q;
   logic               auto_q;
   logic [7:0]         disp_q;
   logic               blank_q;
   logic [REF_W-1:0]   ref_cnt_q;
   logic               tg_q;
   logic [3:0]         nibble;

   logic capture;
   logic advance;
   logic end_scan;
   logic mode_chg;
   logic dwell_run;

`ifdef MEM_SCAN_LOOP_EN
   logic stop_q;  // a start arrived while busy: finish at next advance
`endif

   // ---------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      capture = 1'b0;
      // step and dwell expiry together still give a single advance
      advance = step | (dwell_hit_q & auto_mode);
`ifdef MEM_SCAN_LOOP_EN
      end_scan = stop_q | start;
`else
      end_scan = (rd_addr_q == ADDR_MAX);
`endif
      case (state_q)
         IDLE: begin
            if (start) state_d = REQ;
         end
         REQ: begin
            rd_en   = 1'b1;
            busy    = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (wait_cnt_q == WAIT_W'(RD_LAT - 1)) begin
               capture = 1'b1;
               state_d = SHOW;
            end
         end
         SHOW: begin
            busy = 1'b1;
            if (advance) state_d = end_scan ? DONE : REQ;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Any change of auto_mode restarts the dwell period. The dwell counter
   // saturates at DWELL_CYC-1; reaching it arms dwell_hit_q, which the FSM
   // acts on in the following cycle.
   assign mode_chg  = auto_mode ^ auto_q;
   assign dwell_run = (state_q == SHOW) && (state_d == SHOW) && auto_mode && !mode_chg;

   // auto_mode history only feeds the change detector, so it needs no reset
   always_ff @(posedge clk) begin
      auto_q <= auto_mode;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rd_addr_q   <= '0;
         wait_cnt_q  <= '0;
         dwell_cnt_q <= '0;
         dwell_hit_q <= 1'b0;
         disp_q      <= 8'h00;
         blank_q     <= 1'b1;
         ref_cnt_q   <= '0;
         tg_q        <= 1'b0;
`ifdef MEM_SCAN_LOOP_EN
         stop_q      <= 1'b0;
`endif
      end else begin
         state_q <= state_d;

         if (state_q == SHOW && advance && !end_scan) begin
            rd_addr_q <= rd_addr_q + 1'b1;  // wraps to 0 in loop builds
         end else if (state_q == DONE) begin
            rd_addr_q <= '0;
         end

         if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
         else                 wait_cnt_q <= '0;

         if (dwell_run) begin
            if (dwell_cnt_q != DWELL_W'(DWELL_CYC - 1)) dwell_cnt_q <= dwell_cnt_q + 1'b1;
            dwell_hit_q <= (dwell_cnt_q == DWELL_W'(DWELL_CYC - 1));
         end else begin
            dwell_cnt_q <= '0;
            dwell_hit_q <= 1'b0;
         end

         if (capture) begin
            disp_q  <= rd_data;
            blank_q <= 1'b0;
         end

         // free-running digit multiplexer, independent of the scan
         if (ref_cnt_q == REF_W'(REFRESH_CYC - 1)) begin
            ref_cnt_q <= '0;
            tg_q      <= ~tg_q;
         end else begin
            ref_cnt_q <= ref_cnt_q + 1'b1;
         end

`ifdef MEM_SCAN_LOOP_EN
         if (state_q == IDLE || state_q == DONE) stop_q <= 1'b0;
         else if (start)                         stop_q <= 1'b1;
`endif
      end
   end

   assign rd_addr    = rd_addr_q;
   assign seg_Tg_out = tg_q;
   assign nibble     = tg_q ? disp_q[7:4] : disp_q[3:0];

   hex_to_7seg u_hex (
      .nibble (nibble),
      .blank  (blank_q),
      .seg    (seg)
   );

endmodule

// File: tb/tb_mem_scan_display.sv
// tb_mem_scan_display
//   Self-checking bench for mem_scan_display (ADDR_W=3, RD_LAT=1,
//   DWELL_CYC=4, REFRESH_CYC=2). The register file returns 8'h10+addr.
//   A timeline model (read phase, dwell streak, refresh cycle count) predicts
//   every output each cycle; directed sections add literal expectations.
module tb_mem_scan_display;

   localparam int ADDR_W      = 3;
   localparam int RD_LAT      = 1;
   localparam int DWELL_CYC   = 4;
   localparam int REFRESH_CYC = 2;
   localparam int ADDR_LAST   = (1 << ADDR_W) - 1;
`ifdef MEM_SCAN_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              step = 1'b0;
   logic              auto_mode = 1'b0;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data = 8'h00;
   logic              busy;
   logic              done;
   logic              seg_Tg_out;
   logic [6:0]        seg;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mem_scan_display #(
      .ADDR_W      (ADDR_W),
      .RD_LAT      (RD_LAT),
      .DWELL_CYC   (DWELL_CYC),
      .REFRESH_CYC (REFRESH_CYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .step       (step),
      .auto_mode  (auto_mode),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .busy       (busy),
      .done       (done),
      .seg_Tg_out (seg_Tg_out),
      .seg        (seg)
   );

   // register file: one-cycle read latency, garbage when not reading
   always @(posedge clk) begin
      rd_data <= rd_en ? (8'h10 + 8'(rd_addr)) : 8'($urandom);
   end

   // ---------------- scoreboard bookkeeping ----------------
   int n_chk  = 0;
   int n_fail = 0;
   logic [ADDR_W-1:0] exp_q[$];
   int rd_t_q[$];
   int rd_a_q[$];
   int done_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (rd_en === 1'b1) begin
         rd_t_q.push_back(cyc);
         rd_a_q.push_back(int'(rd_addr));
      end
   end

   // ---------------- behavioural model + per-cycle compare ----------------
   // m_phase: cycles since the read strobe of the current address
   // m_streak: consecutive display cycles with auto_mode held at 1
   bit       m_act = 1'b0;
   bit       m_done = 1'b0;
   int       m_phase = 0;
   int       m_addr = 0;
   int       m_streak = 0;
   bit       m_stop = 1'b0;
   bit       m_prev_auto = 1'b0;
   logic [7:0] m_disp = 8'h00;
   bit       m_blank = 1'b1;
   int       m_ref = 0;

   always @(negedge clk) begin
      bit         e_tg;
      logic [3:0] nib;
      logic [6:0] e_seg;
      bit         adv;
      bit         stop_now;
      if (cyc > 0) begin
         e_tg  = ((m_ref / REFRESH_CYC) % 2) == 1;
         nib   = e_tg ? m_disp[7:4] : m_disp[3:0];
         e_seg = m_blank ? 7'b1111111 : glyph(nib);
         check("rd_en",      32'(rd_en),      32'(m_act && m_phase == 0));
         check("rd_addr",    32'(rd_addr),    32'(m_addr));
         check("busy",       32'(busy),       32'(m_act));
         check("done",       32'(done),       32'(m_done));
         check("seg_Tg_out", 32'(seg_Tg_out), 32'(e_tg));
         check("seg",        32'(seg),        32'(e_seg));
      end
      if (rst) begin
         m_act = 0; m_done = 0; m_phase = 0; m_addr = 0; m_streak = 0;
         m_stop = 0; m_disp = 8'h00; m_blank = 1; m_ref = 0;
      end else begin
         m_ref++;
         if (m_done) begin
            m_done = 0;
            m_addr = 0;
         end else if (!m_act) begin
            if (start) begin
               m_act = 1;
               m_phase = 0;
            end
         end else begin
            stop_now = LOOP && (m_stop || start);
            if (LOOP && start) m_stop = 1;
            if (m_phase < RD_LAT + 1) begin
               if (m_phase == RD_LAT) begin
                  m_disp  = 8'h10 + 8'(m_addr);
                  m_blank = 0;
               end
               m_phase++;
               m_streak = 0;
            end else begin
               m_streak = (auto_mode && m_prev_auto) ? m_streak + 1 : 0;
               adv = step || (auto_mode && m_streak == DWELL_CYC + 1);
               if (adv) begin
                  if (stop_now || (!LOOP && m_addr == ADDR_LAST)) begin
                     m_act = 0; m_done = 1; m_stop = 0;
                  end else begin
                     m_addr = (m_addr + 1) % (ADDR_LAST + 1);
                     m_phase = 0;
                     m_streak = 0;
                  end
               end
            end
         end
      end
      m_prev_auto = auto_mode;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_rd(output int t, output int a);
      bit got;
      got = 1'b0;
      t = -1;
      a = -1;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         if (rd_en === 1'b1) begin
            got = 1'b1;
            t = cyc;
            a = int'(rd_addr);
         end
      end
      check("rd_wait_found", 32'(got), 32'd1);
   endtask

   task automatic finish_scan();
      bit fin;
      fin = 1'b0;
`ifdef MEM_SCAN_LOOP_EN
      pulse_start();
`endif
      for (int k = 0; k < 400 && !fin; k++) begin
         step = 1'b1;
         tick();
         fin = (busy === 1'b0);
      end
      step = 1'b0;
      check("scan_finished", 32'(fin), 32'd1);
      repeat (3) tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t0, t1, t2, t3, a0, a1, a2, a3, t5, d0;
      bit fin;

      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("reset_seg",   32'(seg),        32'h7f);
      check("reset_rd_en", 32'(rd_en),      32'd0);
      check("reset_busy",  32'(busy),       32'd0);
      check("reset_done",  32'(done),       32'd0);
      check("reset_tg",    32'(seg_Tg_out), 32'd0);
      tick();

`ifndef MEM_SCAN_LOOP_EN
      // auto scan: reads at 0..7, seven cycles apart, one done pulse
      exp_q.delete(); rd_t_q.delete(); rd_a_q.delete();
      for (int i = 0; i <= ADDR_LAST; i++) exp_q.push_back(ADDR_W'(i));
      d0 = done_cnt;
      t5 = -100;
      auto_mode = 1'b1;
      pulse_start();
      fin = 1'b0;
      for (int k = 0; k < 200 && !fin; k++) begin
         @(negedge clk);
         if (rd_en === 1'b1 && rd_addr == 3'd5) t5 = cyc;
         if (cyc >= t5 + 2 && cyc <= t5 + 5)
            check("auto_seg_15", 32'(seg), 32'(seg_Tg_out ? 7'b1111001 : 7'b0010010));
         if (done === 1'b1) fin = 1'b1;
      end
      check("auto_done_seen", 32'(fin), 32'd1);
      @(negedge clk);
      check("auto_busy_after", 32'(busy), 32'd0);
      check("auto_done_count", 32'(done_cnt - d0), 32'd1);
      check("auto_rd_count", 32'(rd_t_q.size()), 32'd8);
      for (int i = 0; i < rd_a_q.size() && exp_q.size() > 0; i++) begin
         check("auto_rd_addr", 32'(rd_a_q[i]), 32'(exp_q.pop_front()));
         if (i > 0) check("auto_rd_spacing", 32'(rd_t_q[i] - rd_t_q[i-1]), 32'd7);
      end
      tick();
`else
      // loop scan: wraps back to address 0 without a done pulse
      d0 = done_cnt;
      auto_mode = 1'b1;
      pulse_start();
      t1 = -1;
      for (int i = 0; i <= ADDR_LAST + 1; i++) begin
         wait_rd(t0, a0);
         check("loop_rd_addr", 32'(a0), 32'(i % (ADDR_LAST + 1)));
         if (i > 0) check("loop_rd_spacing", 32'(t0 - t1), 32'd7);
         t1 = t0;
      end
      check("loop_no_done", 32'(done_cnt - d0), 32'd0);
      check("loop_busy", 32'(busy), 32'd1);
      tick();
      pulse_start();
      fin = 1'b0;
      for (int k = 0; k < 50 && !fin; k++) begin
         @(negedge clk);
         if (done === 1'b1) fin = 1'b1;
      end
      check("loop_stop_done", 32'(fin), 32'd1);
      @(negedge clk);
      check("loop_stop_busy", 32'(busy), 32'd0);
      tick();
`endif

      // manual mode: hold address 0, then three steps to address 3
      auto_mode = 1'b0;
      pulse_start();
      repeat (20) tick();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("man_hold_addr", 32'(rd_addr), 32'd0);
         check("man_hold_seg", 32'(seg), 32'(seg_Tg_out ? 7'b1111001 : 7'b1000000));
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         step = 1'b1;
         repeat (3) tick();  // second and third land in REQ and WAIT
         step = 1'b0;
         repeat (6) tick();
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("man_addr3", 32'(rd_addr), 32'd3);
         check("man_seg_13", 32'(seg), 32'(seg_Tg_out ? 7'b1111001 : 7'b0110000));
      end
      tick();
      finish_scan();

      // step coinciding with dwell expiry; start during display of addr 2
      auto_mode = 1'b1;
      pulse_start();
      wait_rd(t0, a0);
      wait_rd(t1, a1);
      check("col_addr1", 32'(a1), 32'd1);
      tick();
      repeat (5) tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      wait_rd(t2, a2);
      check("col_addr2", 32'(a2), 32'd2);
      check("col_time2", 32'(t2 - t1), 32'd7);
      tick();
      repeat (2) tick();
      pulse_start();
      wait_rd(t3, a3);
      check("dist_addr3", 32'(a3), 32'd3);
      check("dist_time3", 32'(t3 - t2), 32'd7);
      check("dist_busy", 32'(busy), 32'd1);
      tick();
      finish_scan();

      // reset while waiting for read data: nothing captured
      auto_mode = 1'b1;
      pulse_start();
      wait_rd(t0, a0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_wait_seg", 32'(seg), 32'h7f);
      check("rst_wait_busy", 32'(busy), 32'd0);
      check("rst_wait_addr", 32'(rd_addr), 32'd0);
      tick();

      // randomized traffic against the model
      auto_mode = 1'($urandom_range(0, 1));
      for (int k = 0; k < 3000; k++) begin
         rst   = ($urandom_range(0, 399) == 0);
         start = ($urandom_range(0, 29) == 0);
         step  = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 59) == 0) auto_mode = ~auto_mode;
         tick();
      end
      rst = 1'b0; start = 1'b0; step = 1'b0;
      repeat (5) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
